// File: rtl/agc_pwm_dac.sv
// PWM output stage for the AGC path: a one-deep shadow buffer feeds a frame-synchronous duty
// register, so duty changes only at frame boundaries. Accepted clipping samples are flagged and counted.
module agc_pwm_dac #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int CLIP_HI  = 250,
    parameter int CLIP_LO  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             clip_flag,
    output logic [7:0]       clip_count,
    input  logic             clip_clear
);

    localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST   = '1;
    localparam logic [WIDTH-1:0] CLIP_HI_V  = WIDTH'(CLIP_HI);
    localparam logic [WIDTH-1:0] CLIP_LO_V  = WIDTH'(CLIP_LO);

    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] shadow;
    logic             pending;

    logic tick;
    logic wrap;
    logic accept;
    logic clip_evt;

    assign tick         = (presc == PRESC_LAST);
    assign wrap         = tick && (cnt == CNT_LAST);
    // The wrap cycle frees the shadow slot, so a stalled sample can be taken in that same cycle.
    assign sample_ready = !pending || wrap;
    assign accept       = sample_valid && sample_ready;
    assign clip_evt     = accept && ((sample_in >= CLIP_HI_V) || (sample_in <= CLIP_LO_V));

    // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            cnt         <= '0;
            duty        <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (tick) begin
                presc <= '0;
                cnt   <= cnt + WIDTH'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            if (wrap && pending) begin
                duty <= shadow;
            end

            if (accept) begin
                shadow  <= sample_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end

            pwm_out     <= (cnt < duty);
            frame_start <= wrap;
        end
    end

    // Clear takes priority, then a same-cycle clipping sample is counted from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_flag  <= 1'b0;
            clip_count <= '0;
        end else if (clip_clear) begin
            clip_flag  <= clip_evt;
            clip_count <= clip_evt ? 8'd1 : 8'd0;
        end else if (clip_evt) begin
            clip_flag <= 1'b1;
            if (clip_count != 8'hFF) begin
                clip_count <= clip_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_agc_pwm_dac.sv
// Directed bench for agc_pwm_dac: main instance (PRESCALE=1), a PRESCALE=3 instance for frame
// length, and a narrow WIDTH=4 instance so clip-count saturation is reached in few frames.
module tb_agc_pwm_dac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       rst = 1'b1;
    logic [7:0] s_in = '0;
    logic       s_valid = 1'b0;
    logic       s_ready, pwm, fs, cflag;
    logic [7:0] ccount;
    logic       cclr = 1'b0;

    // auxiliary instances share one reset
    logic       rst_aux = 1'b1;
    logic [7:0] s3_in = '0;
    logic       s3_valid = 1'b0;
    logic       s3_ready, pwm3, fs3, cflag3;
    logic [7:0] ccount3;
    logic       cclr3 = 1'b0;

    logic [3:0] ss_in = '0;
    logic       ss_valid = 1'b0;
    logic       ss_ready, pwm_s, fs_s, cflag_s;
    logic [7:0] ccount_s;
    logic       cclr_s = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int mcnt   = 0;

    agc_pwm_dac #(.WIDTH(8), .PRESCALE(1), .CLIP_HI(250), .CLIP_LO(5)) dut (
        .clk(clk), .reset(rst), .sample_in(s_in), .sample_valid(s_valid), .sample_ready(s_ready),
        .pwm_out(pwm), .frame_start(fs), .clip_flag(cflag), .clip_count(ccount), .clip_clear(cclr)
    );

    agc_pwm_dac #(.WIDTH(8), .PRESCALE(3), .CLIP_HI(250), .CLIP_LO(5)) dut3 (
        .clk(clk), .reset(rst_aux), .sample_in(s3_in), .sample_valid(s3_valid), .sample_ready(s3_ready),
        .pwm_out(pwm3), .frame_start(fs3), .clip_flag(cflag3), .clip_count(ccount3), .clip_clear(cclr3)
    );

    agc_pwm_dac #(.WIDTH(4), .PRESCALE(1), .CLIP_HI(14), .CLIP_LO(1)) dut_s (
        .clk(clk), .reset(rst_aux), .sample_in(ss_in), .sample_valid(ss_valid), .sample_ready(ss_ready),
        .pwm_out(pwm_s), .frame_start(fs_s), .clip_flag(cflag_s), .clip_count(ccount_s), .clip_clear(cclr_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge. mcnt models the main counter.
    task automatic clk1();
        @(posedge clk);
        #1;
        mcnt = (mcnt + 1) % 256;
    endtask

    task automatic goto_cnt(input int target);
        for (int i = 0; i < 300 && mcnt != target; i++) clk1();
    endtask

    task automatic run_frame(output int hi, output int nfs);
        hi  = 0;
        nfs = 0;
        for (int i = 0; i < 256; i++) begin
            hi  += int'(pwm);
            nfs += int'(fs);
            clk1();
        end
    endtask

    task automatic send1(input string tag, input logic [7:0] val, input logic clr);
        bit done;
        done    = 1'b0;
        s_in    = val;
        s_valid = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            if (s_ready) begin
                cclr = clr;
                done = 1'b1;
            end
            clk1();
        end
        s_valid = 1'b0;
        cclr    = 1'b0;
        check(tag, 32'(done), 1);
    endtask

    int hi, nfs, stalls, n_to;
    bit done_s;

    initial begin
        // 1: reset for two cycles with no valid input
        rst = 1'b1;
        clk1();
        clk1();
        rst  = 1'b0;
        mcnt = 0;
        check("rst_pwm", 32'(pwm), 0);
        check("rst_frame_start", 32'(fs), 0);
        check("rst_ready", 32'(s_ready), 1);
        check("rst_clip_flag", 32'(cflag), 0);
        check("rst_clip_count", 32'(ccount), 0);

        // 2: 0x40 sent at cnt=10, 64/256 duty in the next frame
        goto_cnt(10);
        s_in    = 8'h40;
        s_valid = 1'b1;
        check("t2_ready_before", 32'(s_ready), 1);
        clk1();
        s_valid = 1'b0;
        check("t2_ready_drops", 32'(s_ready), 0);
        goto_cnt(0);
        check("t2_frame_start", 32'(fs), 1);
        run_frame(hi, nfs);
        check("t2_high_count", 32'(hi), 64);
        check("t2_fs_per_frame", 32'(nfs), 1);
        check("t2_fs_period", 32'(fs), 1);

        // 3: 0x10 accepted, 0x20 stalls until the wrap cycle
        goto_cnt(20);
        s_in    = 8'h10;
        s_valid = 1'b1;
        clk1();
        s_in = 8'h20;
        check("t3_stall_ready", 32'(s_ready), 0);
        stalls = 0;
        while (!s_ready && stalls < 300) begin
            clk1();
            stalls++;
        end
        check("t3_stall_len", 32'(stalls), 234);
        check("t3_ready_at_wrap", 32'(mcnt), 255);
        clk1();
        s_valid = 1'b0;
        check("t3_pending_after_wrap", 32'(s_ready), 0);
        check("t3_frame_start", 32'(fs), 1);
        run_frame(hi, nfs);
        check("t3_duty_10", 32'(hi), 16);
        run_frame(hi, nfs);
        check("t3_duty_20", 32'(hi), 32);

        // 4: duty extremes 0x00 and 0xFF
        s_in    = 8'h00;
        s_valid = 1'b1;
        check("t4_ready_00", 32'(s_ready), 1);
        clk1();
        s_valid = 1'b0;
        goto_cnt(0);
        run_frame(hi, nfs);
        check("t4_duty_00", 32'(hi), 0);
        s_in    = 8'hFF;
        s_valid = 1'b1;
        check("t4_ready_ff", 32'(s_ready), 1);
        clk1();
        s_valid = 1'b0;
        goto_cnt(0);
        run_frame(hi, nfs);
        check("t4_duty_ff", 32'(hi), 255);
        check("t4_clip_flag", 32'(cflag), 1);
        check("t4_clip_count", 32'(ccount), 2);

        // 5: clip boundaries, midscale, clear alone, clear with simultaneous clip
        cclr = 1'b1;
        clk1();
        cclr = 1'b0;
        check("t5_clear_flag", 32'(cflag), 0);
        check("t5_clear_count", 32'(ccount), 0);
        send1("t5_send_250", 8'd250, 1'b0);
        send1("t5_send_249", 8'd249, 1'b0);
        send1("t5_send_5", 8'd5, 1'b0);
        send1("t5_send_6", 8'd6, 1'b0);
        check("t5_bound_count", 32'(ccount), 2);
        check("t5_bound_flag", 32'(cflag), 1);
        send1("t5_send_80a", 8'h80, 1'b0);
        send1("t5_send_80b", 8'h80, 1'b0);
        check("t5_mid_count", 32'(ccount), 2);
        send1("t5_send_clr00", 8'h00, 1'b1);
        check("t5_clr_evt_flag", 32'(cflag), 1);
        check("t5_clr_evt_count", 32'(ccount), 1);

        // 6: reset mid-frame while a sample is pending
        send1("t6_send_c0", 8'hC0, 1'b0);
        clk1();
        for (int i = 0; i < 600 && !fs; i++) clk1();
        check("t6_frame_seen", 32'(fs), 1);
        send1("t6_send_e0", 8'hE0, 1'b0);
        goto_cnt(51);
        check("t6_pending", 32'(s_ready), 0);
        check("t6_pwm_mid", 32'(pwm), 1);
        rst = 1'b1;
        clk1();
        clk1();
        rst  = 1'b0;
        mcnt = 0;
        check("t6_pwm_after", 32'(pwm), 0);
        check("t6_ready_after", 32'(s_ready), 1);
        check("t6_fs_after", 32'(fs), 0);
        check("t6_clip_lost", 32'(ccount), 0);
        run_frame(hi, nfs);
        check("t6_frame1_high", 32'(hi), 0);
        run_frame(hi, nfs);
        check("t6_frame2_high", 32'(hi), 0);
        check("t6_frame2_fs", 32'(nfs), 1);

        // 4b: PRESCALE=3 -> 768-cycle frame, 0xFF gives 255 steps x 3 cycles high
        rst_aux = 1'b1;
        clk1();
        clk1();
        rst_aux = 1'b0;
        check("p3_ready", 32'(s3_ready), 1);
        check("p3_fs_reset", 32'(fs3), 0);
        s3_in    = 8'hFF;
        s3_valid = 1'b1;
        clk1();
        s3_valid = 1'b0;
        nfs = 0;
        for (int i = 1; i < 768; i++) begin
            nfs += int'(fs3);
            clk1();
        end
        check("p3_no_early_fs", 32'(nfs), 0);
        check("p3_fs_768", 32'(fs3), 1);
        hi  = 0;
        nfs = 0;
        for (int i = 0; i < 768; i++) begin
            hi  += int'(pwm3);
            nfs += int'(fs3);
            clk1();
        end
        check("p3_high", 32'(hi), 765);
        check("p3_fs_count", 32'(nfs), 1);
        check("p3_fs_1536", 32'(fs3), 1);

        // 5b: 300 clipping samples saturate the count at 255
        n_to = 0;
        for (int n = 1; n <= 301; n++) begin
            ss_in    = (n == 301) ? 4'h8 : 4'hF;
            ss_valid = 1'b1;
            done_s   = 1'b0;
            for (int i = 0; i < 40 && !done_s; i++) begin
                if (ss_ready) done_s = 1'b1;
                clk1();
            end
            ss_valid = 1'b0;
            if (!done_s) n_to++;
            if (n == 254) check("sat_254", 32'(ccount_s), 254);
            if (n == 255) check("sat_255", 32'(ccount_s), 255);
            if (n == 300) check("sat_300", 32'(ccount_s), 255);
        end
        check("sat_timeouts", 32'(n_to), 0);
        check("sat_flag", 32'(cflag_s), 1);
        check("sat_mid_nochange", 32'(ccount_s), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
